// File: rtl/mem_lsu_ysyx23060136_pkg.sv
// Shared definitions for the MEM-stage load/store unit: FSM states, access size
// encodings and byte-lane helpers.
package mem_lsu_ysyx23060136_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } lsu_state_e;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } lsu_size_e;

   localparam logic [3:0] STRB_BYTE = 4'b0001;
   localparam logic [3:0] STRB_HALF = 4'b0011;
   localparam logic [3:0] STRB_WORD = 4'b1111;

   // One-hot {word, half, byte}; anything that is not byte or half is a word.
   function automatic lsu_size_e size_from_onehot(input logic [2:0] oh);
      case (oh)
         3'b001:  return SZ_BYTE;
         3'b010:  return SZ_HALF;
         default: return SZ_WORD;
      endcase
   endfunction

   function automatic logic [3:0] lane_strb(input lsu_size_e size, input logic [1:0] off);
      case (size)
         SZ_BYTE: return STRB_BYTE << off;
         SZ_HALF: return STRB_HALF << {off[1], 1'b0};
         default: return STRB_WORD;
      endcase
   endfunction

endpackage

// File: rtl/mem_lsu_ysyx23060136_if.sv
// Request/grant/response data-bus between the LSU (master) and the memory slave.
interface mem_lsu_ysyx23060136_if;

   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        mem_err;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
      input  mem_gnt, mem_rvalid, mem_rdata, mem_err
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
      output mem_gnt, mem_rvalid, mem_rdata, mem_err
   );

endinterface

// File: rtl/mem_lsu_ysyx23060136_load_ext.sv
// Load lane alignment: shifts the addressed byte/half down to bit 0, then
// sign- or zero-extends it to 32 bits.
module mem_load_ext_ysyx23060136
   import mem_lsu_ysyx23060136_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  offset,
   input  lsu_size_e   size,
   input  logic        is_unsigned,
   output logic [31:0] result
);

   logic [31:0] shifted;

   assign shifted = rdata >> {offset, 3'b000};

   always_comb begin
      result = shifted;
      case (size)
         SZ_BYTE: result = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
         SZ_HALF: result = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
         default: result = shifted;
      endcase
   end

endmodule

// File: rtl/mem_lsu_ysyx23060136.sv
// MEM-stage load/store unit: turns a one-cycle start pulse into a single
// request/grant/response bus transaction and returns the extended load result.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no access in flight; waits for a load or store start pulse
// ST_REQ  | mem_req asserted with frozen command, waiting for mem_gnt
// ST_RESP | command accepted, waiting for mem_rvalid (read data / ack)
module mem_lsu_ysyx23060136
   import mem_lsu_ysyx23060136_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        MEM_i_raddr_change,
   input  logic        MEM_i_waddr_change,
   input  logic [31:0] MEM_i_ALU_ALUout,
   input  logic [31:0] MEM_i_rs2_data,
   input  logic        MEM_i_mem_byte,
   input  logic        MEM_i_mem_half,
   input  logic        MEM_i_mem_word,
   input  logic        MEM_i_mem_byte_u,
   input  logic        MEM_i_mem_half_u,
   mem_lsu_ysyx23060136_if.master bus,
   output logic [31:0] MEM_o_rdata,
   output logic        MEM_o_done,
   output logic        MEM_o_err,
   output logic        MEM_o_busy
);

   lsu_state_e  state_q, state_d;
   logic        start;
   logic        capture;
   logic        finish;
   logic        req_d, req_q;
   logic [31:0] addr_q;
   logic [31:0] data_q;
   lsu_size_e   size_q;
   logic        uns_q;
   logic        we_q;
   logic        done_q;
   logic        err_q;
   logic [31:0] rdata_q;
   logic [31:0] load_val;

   assign start = MEM_i_raddr_change | MEM_i_waddr_change;

   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      finish  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_REQ;
               capture = 1'b1;
            end
         end
         ST_REQ: begin
            if (bus.mem_gnt) state_d = ST_RESP;
         end
         ST_RESP: begin
            if (bus.mem_rvalid) begin
               state_d = ST_IDLE;
               finish  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      req_d = (state_d == ST_REQ);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         req_q   <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         size_q  <= SZ_BYTE;
         uns_q   <= 1'b0;
         we_q    <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         // A simultaneous load and store pulse resolves to the store.
         if (capture) begin
            addr_q <= MEM_i_ALU_ALUout;
            data_q <= MEM_i_rs2_data;
            size_q <= size_from_onehot({MEM_i_mem_word,
                                        MEM_i_mem_half | MEM_i_mem_half_u,
                                        MEM_i_mem_byte | MEM_i_mem_byte_u});
            uns_q  <= MEM_i_mem_byte_u | MEM_i_mem_half_u;
            we_q   <= MEM_i_waddr_change;
         end
         done_q <= finish;
         err_q  <= finish & bus.mem_err;
         if (finish && !we_q) rdata_q <= load_val;
      end
   end

   mem_load_ext_ysyx23060136 u_load_ext (
      .rdata       (bus.mem_rdata),
      .offset      (addr_q[1:0]),
      .size        (size_q),
      .is_unsigned (uns_q),
      .result      (load_val)
   );

   assign bus.mem_req   = req_q;
   assign bus.mem_we    = we_q;
   assign bus.mem_addr  = {addr_q[31:2], 2'b00};
   assign bus.mem_wdata = data_q << {addr_q[1:0], 3'b000};
   assign bus.mem_wstrb = lane_strb(size_q, addr_q[1:0]);

   assign MEM_o_rdata = rdata_q;
   assign MEM_o_done  = done_q;
   assign MEM_o_err   = err_q;
   assign MEM_o_busy  = (state_q != ST_IDLE) | start;

endmodule

// File: tb/tb_mem_lsu_ysyx23060136.sv
// Directed bench for the MEM-stage LSU: a table of load/store vectors driven
// through a cycle-exact bus responder, plus hand-written reset and idle cases.
module tb_mem_lsu_ysyx23060136;

   localparam logic [4:0] F_B  = 5'b10000;
   localparam logic [4:0] F_H  = 5'b01000;
   localparam logic [4:0] F_W  = 5'b00100;
   localparam logic [4:0] F_BU = 5'b10010;
   localparam logic [4:0] F_HU = 5'b01001;

   typedef struct {
      string       name;
      logic        store;
      logic        both;
      logic [31:0] addr;
      logic [31:0] rs2;
      logic [4:0]  flags;
      logic [31:0] rdata;
      logic        err;
      int          gnt_dly;
      int          rv_dly;
      logic        stray;
      logic [31:0] exp_wdata;
      logic [3:0]  exp_strb;
      logic [31:0] exp_rdata;
   } vec_t;

   logic        clk;
   logic        rst;
   logic        raddr_chg, waddr_chg;
   logic [31:0] alu_out, rs2_data;
   logic        m_byte, m_half, m_word, m_byte_u, m_half_u;
   logic [31:0] o_rdata;
   logic        o_done, o_err, o_busy;

   int n_total = 0;
   int n_pass  = 0;

   vec_t vecs[12];

   mem_lsu_ysyx23060136_if bus();

   mem_lsu_ysyx23060136 dut (
      .clk                (clk),
      .rst                (rst),
      .MEM_i_raddr_change (raddr_chg),
      .MEM_i_waddr_change (waddr_chg),
      .MEM_i_ALU_ALUout   (alu_out),
      .MEM_i_rs2_data     (rs2_data),
      .MEM_i_mem_byte     (m_byte),
      .MEM_i_mem_half     (m_half),
      .MEM_i_mem_word     (m_word),
      .MEM_i_mem_byte_u   (m_byte_u),
      .MEM_i_mem_half_u   (m_half_u),
      .bus                (bus.master),
      .MEM_o_rdata        (o_rdata),
      .MEM_o_done         (o_done),
      .MEM_o_err          (o_err),
      .MEM_o_busy         (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic run_vec(input vec_t v);
      logic [31:0] exp_addr;
      exp_addr = {v.addr[31:2], 2'b00};
      @(posedge clk); #1;
      alu_out   = v.addr;
      rs2_data  = v.rs2;
      {m_byte, m_half, m_word, m_byte_u, m_half_u} = v.flags;
      raddr_chg = ~v.store | v.both;
      waddr_chg = v.store;
      @(negedge clk);
      chk({v.name, ".busy_pulse"}, {31'b0, o_busy}, 32'd1);
      chk({v.name, ".req_pulse"}, {31'b0, bus.mem_req}, 32'd0);
      @(posedge clk); #1;
      raddr_chg = 1'b0;
      waddr_chg = 1'b0;
      bus.mem_gnt = (v.gnt_dly == 0);
      for (int i = 0; i < v.gnt_dly; i++) begin
         if (v.stray && i == 0) begin
            raddr_chg = 1'b1;
            alu_out   = 32'hDEAD0000;
         end
         @(negedge clk);
         chk({v.name, ".req_wait"}, {31'b0, bus.mem_req}, 32'd1);
         chk({v.name, ".addr_wait"}, bus.mem_addr, exp_addr);
         @(posedge clk); #1;
         raddr_chg = 1'b0;
         bus.mem_gnt = (i == v.gnt_dly - 1);
      end
      @(negedge clk);
      chk({v.name, ".req_gnt"}, {31'b0, bus.mem_req}, 32'd1);
      chk({v.name, ".we"}, {31'b0, bus.mem_we}, {31'b0, v.store});
      chk({v.name, ".addr"}, bus.mem_addr, exp_addr);
      chk({v.name, ".busy_req"}, {31'b0, o_busy}, 32'd1);
      if (v.store) begin
         chk({v.name, ".wdata"}, bus.mem_wdata, v.exp_wdata);
         chk({v.name, ".wstrb"}, {28'b0, bus.mem_wstrb}, {28'b0, v.exp_strb});
      end
      @(posedge clk); #1;
      bus.mem_gnt    = 1'b0;
      bus.mem_rvalid = (v.rv_dly == 0);
      bus.mem_rdata  = v.rdata;
      bus.mem_err    = v.err;
      for (int i = 0; i < v.rv_dly; i++) begin
         @(negedge clk);
         chk({v.name, ".req_resp"}, {31'b0, bus.mem_req}, 32'd0);
         chk({v.name, ".done_early"}, {31'b0, o_done}, 32'd0);
         @(posedge clk); #1;
         bus.mem_rvalid = (i == v.rv_dly - 1);
      end
      @(negedge clk);
      chk({v.name, ".busy_resp"}, {31'b0, o_busy}, 32'd1);
      chk({v.name, ".done_resp"}, {31'b0, o_done}, 32'd0);
      @(posedge clk); #1;
      bus.mem_rvalid = 1'b0;
      bus.mem_err    = 1'b0;
      @(negedge clk);
      chk({v.name, ".done"}, {31'b0, o_done}, 32'd1);
      chk({v.name, ".err"}, {31'b0, o_err}, {31'b0, v.err});
      chk({v.name, ".busy_done"}, {31'b0, o_busy}, 32'd0);
      chk({v.name, ".rdata"}, o_rdata, v.exp_rdata);
      @(posedge clk); #1;
      @(negedge clk);
      chk({v.name, ".done_once"}, {31'b0, o_done}, 32'd0);
      chk({v.name, ".err_once"}, {31'b0, o_err}, 32'd0);
   endtask

   initial begin
      vecs[0]  = '{"lb_sign", 1'b0, 1'b0, 32'h80000003, 32'h0,        F_B,  32'h80FF1234, 1'b0, 0, 0, 1'b0, 32'h0,        4'h0, 32'hFFFFFF80};
      vecs[1]  = '{"lhu",     1'b0, 1'b0, 32'h80000002, 32'h0,        F_HU, 32'hBEEF0000, 1'b0, 1, 1, 1'b0, 32'h0,        4'h0, 32'h0000BEEF};
      vecs[2]  = '{"sh",      1'b1, 1'b0, 32'h10000002, 32'h0000ABCD, F_H,  32'h55555555, 1'b0, 0, 0, 1'b0, 32'hABCD0000, 4'hC, 32'h0000BEEF};
      vecs[3]  = '{"lw_gnt3", 1'b0, 1'b0, 32'h80000004, 32'h0,        F_W,  32'h12345678, 1'b0, 3, 0, 1'b1, 32'h0,        4'h0, 32'h12345678};
      vecs[4]  = '{"lbu",     1'b0, 1'b0, 32'h80000002, 32'h0,        F_BU, 32'h80FF1234, 1'b0, 0, 0, 1'b0, 32'h0,        4'h0, 32'h000000FF};
      vecs[5]  = '{"lh",      1'b0, 1'b0, 32'h80000000, 32'h0,        F_H,  32'h12348001, 1'b0, 0, 2, 1'b0, 32'h0,        4'h0, 32'hFFFF8001};
      vecs[6]  = '{"sb",      1'b1, 1'b0, 32'h20000001, 32'h000000A5, F_B,  32'h0,        1'b0, 1, 0, 1'b0, 32'h0000A500, 4'h2, 32'hFFFF8001};
      vecs[7]  = '{"sw_err",  1'b1, 1'b0, 32'h20000008, 32'hDEADBEEF, F_W,  32'h0,        1'b1, 0, 0, 1'b0, 32'hDEADBEEF, 4'hF, 32'hFFFF8001};
      vecs[8]  = '{"both",    1'b1, 1'b1, 32'h30000000, 32'hCAFEF00D, F_W,  32'h11111111, 1'b0, 0, 0, 1'b0, 32'hCAFEF00D, 4'hF, 32'hFFFF8001};
      vecs[9]  = '{"lh_mis",  1'b0, 1'b0, 32'h80000003, 32'h0,        F_H,  32'hAB000000, 1'b0, 0, 0, 1'b0, 32'h0,        4'h0, 32'h000000AB};
      vecs[10] = '{"sh_mis",  1'b1, 1'b0, 32'h10000003, 32'h00001234, F_H,  32'h0,        1'b0, 0, 1, 1'b0, 32'h34000000, 4'hC, 32'h000000AB};
      vecs[11] = '{"lb_post", 1'b0, 1'b0, 32'h00000000, 32'h0,        F_B,  32'h0000007F, 1'b0, 0, 0, 1'b0, 32'h0,        4'h0, 32'h0000007F};

      rst = 1'b1;
      raddr_chg = 1'b0; waddr_chg = 1'b0;
      alu_out = '0; rs2_data = '0;
      {m_byte, m_half, m_word, m_byte_u, m_half_u} = 5'b0;
      bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0; bus.mem_err = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst.req",   {31'b0, bus.mem_req}, 32'd0);
      chk("rst.done",  {31'b0, o_done}, 32'd0);
      chk("rst.err",   {31'b0, o_err}, 32'd0);
      chk("rst.rdata", o_rdata, 32'd0);
      chk("rst.busy",  {31'b0, o_busy}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      for (int k = 0; k < 11; k++) run_vec(vecs[k]);

      // Reset while waiting for the response abandons the access.
      @(posedge clk); #1;
      alu_out = 32'h80000000;
      {m_byte, m_half, m_word, m_byte_u, m_half_u} = F_W;
      raddr_chg = 1'b1;
      @(posedge clk); #1;
      raddr_chg = 1'b0;
      bus.mem_gnt = 1'b1;
      @(posedge clk); #1;
      bus.mem_gnt = 1'b0;
      @(negedge clk);
      chk("rstmid.busy_resp", {31'b0, o_busy}, 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("rstmid.busy", {31'b0, o_busy}, 32'd0);
      chk("rstmid.req",  {31'b0, bus.mem_req}, 32'd0);
      @(negedge clk);
      chk("rstmid.done",  {31'b0, o_done}, 32'd0);
      chk("rstmid.rdata", o_rdata, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'hFFFFFFFF;
      bus.mem_err    = 1'b1;
      @(posedge clk); #1;
      bus.mem_rvalid = 1'b0;
      bus.mem_err    = 1'b0;
      @(negedge clk);
      chk("idle_rv.done",  {31'b0, o_done}, 32'd0);
      chk("idle_rv.err",   {31'b0, o_err}, 32'd0);
      chk("idle_rv.rdata", o_rdata, 32'd0);
      chk("idle_rv.busy",  {31'b0, o_busy}, 32'd0);
      chk("idle_rv.req",   {31'b0, bus.mem_req}, 32'd0);

      run_vec(vecs[11]);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "bench time limit");
   end

endmodule
